wb_regfile: RTL and testbench

- Write-back stage plus architectural register file of the pipelined MIPS datapath.
- Consumes the MEM/WB pipeline register outputs, which carry the load data, ALU result, destination register, regWrite and memToReg.
- Selects the write-back value, commits it to the 32x32 register file and serves the two ID-stage read ports.
- Provides same-cycle write-through bypass, so an ID-stage read of the register being written returns the new value.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/regfile_core.sv | 46 ++++
 rtl/wb_regfile.sv | 87 ++++++++
 tb/tb_wb_regfile.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS datapath slice.
// Provides the data/index widths, register count and symbolic register
// indices used by the write-back stage and its benches.
package mips_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NREGS  = 32;

    // Architectural register indices
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_AT   = 5'd1;
    localparam logic [4:0] REG_V0   = 5'd2;
    localparam logic [4:0] REG_A0   = 5'd4;
    localparam logic [4:0] REG_T0   = 5'd8;
    localparam logic [4:0] REG_T1   = 5'd9;
    localparam logic [4:0] REG_SP   = 5'd29;
    localparam logic [4:0] REG_FP   = 5'd30;
    localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/regfile_core.sv
// Raw register storage for the write-back stage.
// Ports:
//   clk, reset          - clock and synchronous active-high reset (clears all entries)
//   we, waddr, wdata    - single write port, committed on the rising edge
//   raddr1/2, rdata1/2  - combinational read ports (no bypass, no zero forcing)
//   raddr3, rdata3      - combinational peek port
module regfile_core
    import mips_pkg::*;
#(
    parameter int unsigned DW = mips_pkg::DATA_W,
    parameter int unsigned AW = mips_pkg::ADDR_W,
    parameter int unsigned NR = mips_pkg::NREGS
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    input  logic [AW-1:0] raddr3,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2,
    output logic [DW-1:0] rdata3
);

    logic [DW-1:0] regs [NR];

    // Reset wins over a write presented in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NR); i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = regs[raddr1];
        rdata2 = regs[raddr2];
        rdata3 = regs[raddr3];
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage plus the 32x32 architectural register file.
// Ports:
//   clk, reset                 - pipeline clock, synchronous active-high reset
//   readDataIn, ALUOutIn       - candidate write-back values from MEM/WB
//   regFromMuxIn, regWrite     - destination index and write enable from MEM/WB
//   memToReg                   - 1 selects load data, 0 selects the ALU result
//   readReg1/2, readData1/2    - ID-stage read ports with same-cycle write-through
//   wbData, wbValid            - selected write-back value and commit qualifier
//   dbgAddr, dbgData           - raw storage peek (no bypass), r0 reads as zero
module wb_regfile
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = mips_pkg::DATA_W,
    parameter int unsigned ADDR_W = mips_pkg::ADDR_W,
    parameter int unsigned NREGS  = mips_pkg::NREGS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] readDataIn,
    input  logic [DATA_W-1:0] ALUOutIn,
    input  logic [ADDR_W-1:0] regFromMuxIn,
    input  logic              regWrite,
    input  logic              memToReg,
    input  logic [ADDR_W-1:0] readReg1,
    input  logic [ADDR_W-1:0] readReg2,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    output logic [DATA_W-1:0] wbData,
    output logic              wbValid,
    input  logic [ADDR_W-1:0] dbgAddr,
    output logic [DATA_W-1:0] dbgData
);

    if (NREGS != (1 << ADDR_W)) begin : g_bad_nregs
        $error("wb_regfile: NREGS must equal 2**ADDR_W");
    end

    localparam logic [ADDR_W-1:0] ZeroIdx = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] raw1;
    logic [DATA_W-1:0] raw2;
    logic [DATA_W-1:0] rawdbg;

    regfile_core #(
        .DW (DATA_W),
        .AW (ADDR_W),
        .NR (NREGS)
    ) u_core (
        .clk    (clk),
        .reset  (reset),
        .we     (wbValid),
        .waddr  (regFromMuxIn),
        .wdata  (wbData),
        .raddr1 (readReg1),
        .raddr2 (readReg2),
        .raddr3 (dbgAddr),
        .rdata1 (raw1),
        .rdata2 (raw2),
        .rdata3 (rawdbg)
    );

    always_comb begin
        wbData  = memToReg ? readDataIn : ALUOutIn;
        // Gating with reset also disables the bypass during reset, so reads
        // then show the stored value.
        wbValid = regWrite && (regFromMuxIn != ZeroIdx) && !reset;

        if (readReg1 == ZeroIdx) begin
            readData1 = '0;
        end else if (wbValid && (readReg1 == regFromMuxIn)) begin
            readData1 = wbData;
        end else begin
            readData1 = raw1;
        end

        if (readReg2 == ZeroIdx) begin
            readData2 = '0;
        end else if (wbValid && (readReg2 == regFromMuxIn)) begin
            readData2 = wbData;
        end else begin
            readData2 = raw2;
        end

        dbgData = (dbgAddr == ZeroIdx) ? '0 : rawdbg;
    end

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] readDataIn = '0;
    logic [31:0] ALUOutIn = '0;
    logic [4:0]  regFromMuxIn = '0;
    logic        regWrite = 1'b0;
    logic        memToReg = 1'b0;
    logic [4:0]  readReg1 = '0;
    logic [4:0]  readReg2 = '0;
    logic [4:0]  dbgAddr = '0;
    logic [31:0] readData1;
    logic [31:0] readData2;
    logic [31:0] wbData;
    logic        wbValid;
    logic [31:0] dbgData;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk          (clk),
        .reset        (reset),
        .readDataIn   (readDataIn),
        .ALUOutIn     (ALUOutIn),
        .regFromMuxIn (regFromMuxIn),
        .regWrite     (regWrite),
        .memToReg     (memToReg),
        .readReg1     (readReg1),
        .readReg2     (readReg2),
        .readData1    (readData1),
        .readData2    (readData2),
        .wbData       (wbData),
        .wbValid      (wbValid),
        .dbgAddr      (dbgAddr),
        .dbgData      (dbgData)
    );

    typedef struct {
        logic        rst;
        logic        rw;
        logic        m2r;
        logic [4:0]  wreg;
        logic [31:0] alu;
        logic [31:0] ld;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  dbg;
        logic        e_wbv;
        logic [31:0] e_wbd;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic [31:0] e_pre;
        logic [31:0] e_post;
    } vec_t;

    typedef struct {
        string       name;
        logic        wbv;
        logic [31:0] wbd;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] dbg;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[12];
    logic [31:0] model[32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Control inputs must never be X outside reset.
    always @(posedge clk) begin
        if (!reset) begin
            checks++;
            if ($isunknown({regWrite, memToReg})) begin
                errors++;
                $display("FAIL x_ctrl: got %b%b expected known", regWrite, memToReg);
            end
        end
    end

    function automatic vec_t mk(input logic rst, input logic rw, input logic m2r,
                                input logic [4:0] wreg, input logic [31:0] alu,
                                input logic [31:0] ld, input logic [4:0] r1,
                                input logic [4:0] r2, input logic [4:0] dbg,
                                input logic e_wbv, input logic [31:0] e_wbd,
                                input logic [31:0] e_rd1, input logic [31:0] e_rd2,
                                input logic [31:0] e_pre, input logic [31:0] e_post);
        vec_t v;
        v.rst = rst; v.rw = rw; v.m2r = m2r; v.wreg = wreg; v.alu = alu; v.ld = ld;
        v.r1 = r1; v.r2 = r2; v.dbg = dbg; v.e_wbv = e_wbv; v.e_wbd = e_wbd;
        v.e_rd1 = e_rd1; v.e_rd2 = e_rd2; v.e_pre = e_pre; v.e_post = e_post;
        return v;
    endfunction

    task automatic drive(input logic rst, input logic rw, input logic m2r,
                         input logic [4:0] wreg, input logic [31:0] alu, input logic [31:0] ld,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dbg);
        reset = rst; regWrite = rw; memToReg = m2r; regFromMuxIn = wreg;
        ALUOutIn = alu; readDataIn = ld; readReg1 = r1; readReg2 = r2; dbgAddr = dbg;
    endtask

    // Pops the oldest expectation and compares against the settled outputs.
    task automatic check_sb();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: got 0 entries expected 1");
            return;
        end
        checks--;
        e = sb.pop_front();
        chk({e.name, ".wbValid"}, {31'd0, wbValid}, {31'd0, e.wbv});
        chk({e.name, ".wbData"}, wbData, e.wbd);
        chk({e.name, ".readData1"}, readData1, e.rd1);
        chk({e.name, ".readData2"}, readData2, e.rd2);
        chk({e.name, ".dbgData_pre"}, dbgData, e.dbg);
    endtask

    initial begin
        exp_t e;
        // Reset held for two edges
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset then read all
        for (int i = 0; i < 32; i++) begin
            dbgAddr = 5'(i); readReg1 = 5'(i); readReg2 = 5'(31 - i);
            #0.25;
            chk($sformatf("reset_dbg[%0d]", i), dbgData, 32'h0);
            chk($sformatf("reset_rd1[%0d]", i), readData1, 32'h0);
            chk($sformatf("reset_rd2[%0d]", i), readData2, 32'h0);
        end

        vecs[0]  = mk(0, 1, 0, REG_T0, 32'h1234_5678, 32'h5555_5555, REG_T0, REG_AT, REG_T0,
                      1, 32'h1234_5678, 32'h1234_5678, 32'h0, 32'h0, 32'h1234_5678);
        vecs[1]  = mk(0, 1, 1, REG_T0, 32'h1234_5678, 32'hDEAD_BEEF, REG_V0, REG_T0, REG_T0,
                      1, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 32'h1234_5678, 32'hDEAD_BEEF);
        vecs[2]  = mk(0, 1, 0, REG_T1, 32'hCAFE_0001, 32'h0, REG_T1, REG_T1, REG_T1,
                      1, 32'hCAFE_0001, 32'hCAFE_0001, 32'hCAFE_0001, 32'h0, 32'hCAFE_0001);
        vecs[3]  = mk(0, 1, 0, REG_ZERO, 32'hFFFF_FFFF, 32'h0, REG_ZERO, REG_T0, REG_ZERO,
                      0, 32'hFFFF_FFFF, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0);
        vecs[4]  = mk(0, 0, 0, REG_ZERO, 32'h0, 32'h0, REG_ZERO, REG_T1, REG_ZERO,
                      0, 32'h0, 32'h0, 32'hCAFE_0001, 32'h0, 32'h0);
        vecs[5]  = mk(0, 0, 0, 5'd5, 32'hAAAA_AAAA, 32'h0, 5'd5, 5'd5, 5'd5,
                      0, 32'hAAAA_AAAA, 32'h0, 32'h0, 32'h0, 32'h0);
        vecs[6]  = mk(0, 1, 0, 5'd3, 32'h11, 32'h0, 5'd3, REG_T0, 5'd3,
                      1, 32'h11, 32'h11, 32'hDEAD_BEEF, 32'h0, 32'h11);
        vecs[7]  = mk(1, 1, 0, 5'd3, 32'h22, 32'h0, 5'd3, REG_T1, 5'd3,
                      0, 32'h22, 32'h11, 32'hCAFE_0001, 32'h11, 32'h0);
        vecs[8]  = mk(0, 1, 0, 5'd3, 32'h22, 32'h0, REG_T1, REG_T0, 5'd3,
                      1, 32'h22, 32'h0, 32'h0, 32'h0, 32'h22);
        vecs[9]  = mk(0, 0, 0, 5'd3, 32'h0, 32'h0, 5'd3, REG_T0, REG_T1,
                      0, 32'h0, 32'h22, 32'h0, 32'h0, 32'h0);
        vecs[10] = mk(0, 1, 1, REG_RA, 32'h1, 32'h0BAD_F00D, REG_RA, 5'd3, REG_RA,
                      1, 32'h0BAD_F00D, 32'h0BAD_F00D, 32'h22, 32'h0, 32'h0BAD_F00D);
        vecs[11] = mk(0, 1, 0, REG_A0, 32'h44, 32'h0, REG_RA, REG_A0, REG_A0,
                      1, 32'h44, 32'h0BAD_F00D, 32'h44, 32'h0, 32'h44);

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].rw, vecs[i].m2r, vecs[i].wreg, vecs[i].alu,
                  vecs[i].ld, vecs[i].r1, vecs[i].r2, vecs[i].dbg);
            e.name = $sformatf("vec%0d", i);
            e.wbv = vecs[i].e_wbv; e.wbd = vecs[i].e_wbd;
            e.rd1 = vecs[i].e_rd1; e.rd2 = vecs[i].e_rd2; e.dbg = vecs[i].e_pre;
            sb.push_back(e);
            #4;
            check_sb();
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.dbgData_post", i), dbgData, vecs[i].e_post);
        end

        // Random traffic against a behavioural model; clear both first.
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        for (int i = 0; i < 32; i++) model[i] = '0;
        for (int n = 0; n < 300; n++) begin
            logic        rst, rw, m2r;
            logic [4:0]  wreg, r1, r2, dbg;
            logic [31:0] alu, ld;
            @(negedge clk);
            rst  = ($urandom_range(0, 39) == 0);
            rw   = 1'($urandom_range(0, 3) != 0);
            m2r  = 1'($urandom_range(0, 1));
            wreg = 5'($urandom_range(0, 31));
            alu  = $urandom;
            ld   = $urandom;
            r1   = $urandom_range(0, 1) ? wreg : 5'($urandom_range(0, 31));
            r2   = $urandom_range(0, 2) == 0 ? wreg : 5'($urandom_range(0, 31));
            dbg  = $urandom_range(0, 1) ? wreg : 5'($urandom_range(0, 31));
            drive(rst, rw, m2r, wreg, alu, ld, r1, r2, dbg);
            e.name = $sformatf("rand%0d", n);
            e.wbv  = rw && (wreg != 0) && !rst;
            e.wbd  = m2r ? ld : alu;
            e.rd1  = (r1 == 0) ? 32'h0 : (e.wbv && r1 == wreg) ? e.wbd : model[r1];
            e.rd2  = (r2 == 0) ? 32'h0 : (e.wbv && r2 == wreg) ? e.wbd : model[r2];
            e.dbg  = (dbg == 0) ? 32'h0 : model[dbg];
            sb.push_back(e);
            #4;
            check_sb();
            @(posedge clk);
            if (rst) begin
                for (int i = 0; i < 32; i++) model[i] = '0;
            end else if (e.wbv) begin
                model[wreg] = e.wbd;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
